// File: rtl/reg_bank_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_arbiter_pkg
// Description : Shared state encoding and requester IDs for reg_bank_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bank_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/reg_bank_arbiter_bank.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank
// Description : DEPTH x WIDTH flop register array, sync write, strobed registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank
    import reg_bank_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (we) begin
                r_mem[addr] <= wdata;
            end
            // Holds the last read result between strobes.
            if (re) begin
                r_rdata <= r_mem[raddr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_arbiter
// Description : Round-robin 2-requester req/gnt arbiter around a shared register bank.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             we0,
    input  logic [AW-1:0]    addr0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             req1,
    input  logic             we1,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid,
    output logic             rid,
    output logic [WIDTH-1:0] rdata,
    output logic             busy
);

    state_t           r_state;
    logic             r_last;
    logic             r_cmd_id;
    logic             r_cmd_we;
    logic [AW-1:0]    r_cmd_addr;
    logic [WIDTH-1:0] r_cmd_wdata;

    logic             w_winner;
    logic             w_win_req;
    logic             w_bank_we;
    logic             w_bank_re;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_winner = REQ0;
        if (req0 && req1) begin
            w_winner = ~r_last;
        end else if (req1) begin
            w_winner = REQ1;
        end
    end

    assign w_win_req = (r_cmd_id == REQ1) ? req1 : req0;
    assign w_bank_we = (r_state == ST_ACCESS) &&  r_cmd_we;
    assign w_bank_re = (r_state == ST_ACCESS) && !r_cmd_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_last      <= REQ1;
            r_cmd_id    <= REQ0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rvalid      <= 1'b0;
            rid         <= REQ0;
            busy        <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        r_cmd_id    <= w_winner;
                        r_last      <= w_winner;
                        r_cmd_we    <= (w_winner == REQ1) ? we1    : we0;
                        r_cmd_addr  <= (w_winner == REQ1) ? addr1  : addr0;
                        r_cmd_wdata <= (w_winner == REQ1) ? wdata1 : wdata0;
                        gnt0        <= (w_winner == REQ0);
                        gnt1        <= (w_winner == REQ1);
                        busy        <= 1'b1;
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!r_cmd_we) begin
                        rvalid <= 1'b1;
                        rid    <= r_cmd_id;
                    end
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!w_win_req) begin
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    reg_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (w_bank_we),
        .re      (w_bank_re),
        .addr    (r_cmd_addr),
        .wdata   (r_cmd_wdata),
        .raddr   (r_cmd_addr),
        .rdata   (rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_arbiter
// Description : Directed table-driven bench for reg_bank_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [1:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid, rid, busy;
    logic [7:0] rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         id;
        bit         we;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    reg_bank_arbiter #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid(rvalid), .rid(rid),
        .rdata(rdata), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit id, input bit rq, input bit w, input logic [1:0] a, input logic [7:0] d);
        if (id) begin
            req1 = rq; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = rq; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    // One full command from an idle arbiter, requester drops req as soon as gnt is seen.
    task automatic do_cmd(input bit id, input bit w, input logic [1:0] a, input logic [7:0] d, input logic [7:0] exp);
        int n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("idle_timeout", 32'(busy), 32'd0);
        drive(id, 1'b1, w, a, d);
        step();
        chk("gnt_rise", 32'(id ? gnt1 : gnt0), 32'd1);
        chk("gnt_other", 32'(id ? gnt0 : gnt1), 32'd0);
        drive(id, 1'b0, w, a, d);
        step();
        if (!w) begin
            chk("rvalid", 32'(rvalid), 32'd1);
            chk("rid", 32'(rid), 32'(id));
            chk("rdata", 32'(rdata), 32'(exp));
        end else begin
            chk("rvalid_wr", 32'(rvalid), 32'd0);
        end
        step();
        chk("gnt_fall", 32'({gnt0, gnt1}), 32'd0);
        chk("busy_idle", 32'({busy, rvalid}), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 2'd1, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 2'd2, 8'h00, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 2'd3, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 8'h00};
        vecs[5]  = '{1'b0, 1'b0, 2'd2, 8'h00, 8'hA5};
        vecs[6]  = '{1'b1, 1'b1, 2'd3, 8'h5A, 8'h00};
        vecs[7]  = '{1'b0, 1'b0, 2'd3, 8'h00, 8'h5A};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 8'hC3, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'hC3};
        vecs[10] = '{1'b1, 1'b0, 2'd2, 8'h00, 8'hA5};

        // Asynchronous reset with noisy inputs.
        #2 reset_n = 1'b0;
        #1 chk("reset_async", 32'({gnt0, gnt1, rvalid, rid, busy, rdata}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req0 = 1'($urandom); req1 = 1'($urandom);
            we0 = 1'($urandom); we1 = 1'($urandom);
            addr0 = 2'($urandom); addr1 = 2'($urandom);
            wdata0 = 8'($urandom); wdata1 = 8'($urandom);
            #1 chk("reset_hold", 32'({gnt0, gnt1, rvalid, rid, busy, rdata}), 32'd0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        reset_n = 1'b1;
        step();
        chk("idle_after_reset", 32'({gnt0, gnt1, busy, rvalid}), 32'd0);

        for (int i = 0; i < 11; i++) begin
            do_cmd(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
        end

        // Tie: last served was requester 1, so grants go 0,1,0,1.
        drive(1'b0, 1'b1, 1'b1, 2'd1, 8'h11);
        drive(1'b1, 1'b1, 1'b1, 2'd1, 8'h22);
        step();
        chk("tie1_gnt", 32'({gnt0, gnt1}), 32'b10);
        req0 = 1'b0;
        step();
        step();
        chk("tie1_rel", 32'({gnt0, gnt1}), 32'b00);
        drive(1'b0, 1'b1, 1'b0, 2'd1, 8'h00);
        step();
        chk("tie2_gnt", 32'({gnt0, gnt1}), 32'b01);
        req1 = 1'b0;
        step();
        step();
        chk("tie2_rel", 32'({gnt0, gnt1}), 32'b00);
        drive(1'b1, 1'b1, 1'b0, 2'd1, 8'h00);
        step();
        chk("tie3_gnt", 32'({gnt0, gnt1}), 32'b10);
        req0 = 1'b0;
        step();
        chk("tie3_rd", 32'({rvalid, rid, rdata}), {22'd0, 1'b1, 1'b0, 8'h22});
        step();
        step();
        chk("tie4_gnt", 32'({gnt0, gnt1}), 32'b01);
        req1 = 1'b0;
        step();
        chk("tie4_rd", 32'({rvalid, rid, rdata}), {22'd0, 1'b1, 1'b1, 8'h22});
        step();
        chk("tie4_rel", 32'({gnt0, gnt1, busy}), 32'd0);

        // Requester 1 holds req after gnt; requester 0 must wait, bank written once.
        drive(1'b1, 1'b1, 1'b1, 2'd0, 8'h77);
        step();
        chk("hold_gnt", 32'({gnt0, gnt1}), 32'b01);
        wdata1 = 8'h88;
        drive(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_keep", 32'({gnt0, gnt1, busy}), 32'b011);
        end
        req1 = 1'b0;
        step();
        chk("hold_drop", 32'({gnt0, gnt1}), 32'b00);
        step();
        chk("hold_next", 32'({gnt0, gnt1}), 32'b10);
        req0 = 1'b0;
        step();
        chk("hold_rd", 32'({rvalid, rid, rdata}), {22'd0, 1'b1, 1'b0, 8'h77});
        step();

        // Write data changes right after arbitration; latched value must win.
        drive(1'b0, 1'b1, 1'b1, 2'd3, 8'h3C);
        step();
        chk("latch_gnt", 32'(gnt0), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 2'd3, 8'hFF);
        step();
        step();
        do_cmd(1'b0, 1'b0, 2'd3, 8'h00, 8'h3C);

        // Reset while requester 0 sits in RELEASE.
        drive(1'b0, 1'b1, 1'b1, 2'd2, 8'h99);
        step();
        step();
        chk("mid_gnt", 32'({gnt0, busy}), 32'b11);
        #2 reset_n = 1'b0;
        #1 chk("mid_reset", 32'({gnt0, gnt1, rvalid, rid, busy, rdata}), 32'd0);
        @(negedge clk);
        req0 = 1'b0;
        reset_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 2'd2, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 2'd3, 8'h00);
        step();
        chk("post_tie", 32'({gnt0, gnt1}), 32'b10);
        req0 = 1'b0;
        step();
        chk("post_rd0", 32'({rvalid, rid, rdata}), {22'd0, 1'b1, 1'b0, 8'h00});
        step();
        step();
        chk("post_gnt1", 32'({gnt0, gnt1}), 32'b01);
        req1 = 1'b0;
        step();
        chk("post_rd1", 32'({rvalid, rid, rdata}), {22'd0, 1'b1, 1'b1, 8'h00});
        step();
        chk("post_idle", 32'({gnt0, gnt1, busy}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
